// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single shared data-memory port.
// Requester 0 is the core load/store unit, requester 1 the loader/debug path.
// Ownership is granted per requester for bursts of up to MAX_BURST beats.
// While the other side is waiting, ownership then passes over with no idle cycle.
// Read data is registered: rvalid_x/rdata_x appear one cycle after the grant.
//
// Handshake: req_x is the requester's "valid". gnt_x acts as "ready".
// A beat transfers in any cycle where gnt_x=1, and gnt_x is only ever 1 while
// req_x=1. The requester keeps req/we/addr/wdata stable until it sees gnt_x;
// the arbiter never latches request fields.
module mem_port_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  localparam logic [4:0] MAX_B5 = 5'(MAX_BURST);
  localparam logic [3:0] MAX_B4 = 4'(MAX_BURST);

  logic [1:0] state, state_nxt;
  logic       last_owner, last_owner_nxt;
  logic [3:0] beat_cnt, beat_cnt_nxt;

  logic [4:0] cnt_inc;
  logic       burst_done;
  logic [3:0] cnt_sat;

  // Grants are purely combinational from the current owner and its request.
  assign gnt0      = (state == OWN0) & req0;
  assign gnt1      = (state == OWN1) & req1;
  assign state_dbg = state;

  // The ">=" compare also covers a saturated count: when the other requester
  // arrives after a long solo burst, ownership still passes on that beat.
  assign cnt_inc    = {1'b0, beat_cnt} + 5'd1;
  assign burst_done = (cnt_inc >= MAX_B5);
  assign cnt_sat    = burst_done ? MAX_B4 : cnt_inc[3:0];

  // Shared port mux: the granted requester drives the port, otherwise it idles at zero.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (gnt0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  // Ownership FSM: arbitration from IDLE, burst limiting, and hand-over.
  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    beat_cnt_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        // On a tie, favour the side that did not own the port last.
        if (req0 && (!req1 || last_owner)) state_nxt = OWN0;
        else if (req1)                     state_nxt = OWN1;
      end
      OWN0: begin
        if (!req0) begin
          last_owner_nxt = 1'b0;
          beat_cnt_nxt   = 4'd0;
          state_nxt      = req1 ? OWN1 : IDLE;
        end else if (burst_done && req1) begin
          last_owner_nxt = 1'b0;
          beat_cnt_nxt   = 4'd0;
          state_nxt      = OWN1;
        end else begin
          beat_cnt_nxt   = cnt_sat;
        end
      end
      OWN1: begin
        if (!req1) begin
          last_owner_nxt = 1'b1;
          beat_cnt_nxt   = 4'd0;
          state_nxt      = req0 ? OWN0 : IDLE;
        end else if (burst_done && req0) begin
          last_owner_nxt = 1'b1;
          beat_cnt_nxt   = 4'd0;
          state_nxt      = OWN0;
        end else begin
          beat_cnt_nxt   = cnt_sat;
        end
      end
      default: begin
        state_nxt    = IDLE;
        beat_cnt_nxt = 4'd0;
      end
    endcase
  end

  // FSM registers; reset leaves requester 0 favoured on the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      beat_cnt   <= 4'd0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  // Registered read return: capture memory data on a granted read only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= 32'h0;
      rdata1  <= 32'h0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (gnt0 && !we0) rdata0 <= mem_rdata;
      if (gnt1 && !we1) rdata1 <= mem_rdata;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, meaning the maximum consecutive granted beats per owner while the other requester waits (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (rst=0 resets).
REQ-004 SHALL have ports req0/req1, input, 1 bit each: requester 0 (core load/store) / requester 1 (loader/debug) access request.
REQ-005 SHALL have ports we0/we1, input, 1 bit each: write enable of requester.
REQ-006 SHALL have ports addr0/addr1, input, 32 bits each: word address of requester.
REQ-007 SHALL have ports wdata0/wdata1, input, 32 bits each: write data of requester.
REQ-008 SHALL have ports gnt0/gnt1, output, 1 bit each: beat accepted this cycle.
REQ-009 SHALL have ports rvalid0/rvalid1, output, 1 bit each: read data valid for the read accepted one cycle earlier.
REQ-010 SHALL have ports rdata0/rdata1, output, 32 bits each: registered read data.
REQ-011 SHALL have ports mem_we, output, 1 bit; mem_addr, output, 32 bits; mem_wdata, output, 32 bits: shared data-memory port.
REQ-012 SHALL have port mem_rdata, input, 32 bits: combinational read data of the shared memory for mem_addr.

Function
REQ-013 SHALL implement FSM states IDLE, OWN0, OWN1, plus registers last_owner (1 bit), beat_cnt (4 bits).
REQ-014 IDLE: req0 only -> OWN0; req1 only -> OWN1; both -> OWN of requester != last_owner; none -> stay IDLE.
REQ-015 gnt_x SHALL equal (state==OWNx) & req_x, combinationally; no grant in IDLE.
REQ-016 While gnt_x=1, mem_we/mem_addr/mem_wdata SHALL equal we_x/addr_x/wdata_x; otherwise mem_we=0, mem_addr=0, mem_wdata=0.
REQ-017 Each cycle gnt_x=1 SHALL increment beat_cnt, saturating at MAX_BURST.
REQ-018 OWNx with req_x=0: last_owner<=x, beat_cnt<=0, next state OWN(other) if other req high else IDLE (one bubble cycle).
REQ-019 OWNx with gnt_x=1 and beat_cnt+1==MAX_BURST and other req high: next state OWN(other), last_owner<=x, beat_cnt<=0 (no bubble; other granted next cycle).
REQ-020 OWNx with gnt_x=1 and other req low: stay OWNx irrespective of beat_cnt; beat_cnt saturates.
REQ-021 Granted read (gnt_x=1, we_x=0): rdata_x<=mem_rdata and rvalid_x<=1 at that edge; rvalid_x SHALL be 0 in all other cycles; rdata_x holds its last value otherwise.
REQ-022 Granted write SHALL not assert rvalid_x nor change rdata_x.
REQ-023 Requester SHALL hold req/we/addr/wdata stable until gnt; arbiter assumes this and does not latch request fields.
REQ-024 At most one of gnt0/gnt1 SHALL be 1 in any cycle.
REQ-025 Request-to-first-grant latency from IDLE SHALL be exactly 1 cycle; grant-to-rvalid latency exactly 1 cycle.

Reset
REQ-026 rst=0 SHALL immediately force state=IDLE, last_owner=1 (requester 0 favoured first), beat_cnt=0, rvalid0=rvalid1=0, rdata0=rdata1=0, hence gnt0=gnt1=0 and mem_we=0.
REQ-027 Reset asserted mid-burst SHALL abort ownership with no further grants; a read granted in the same cycle as reset assertion SHALL not produce rvalid.
REQ-028 After rst returns to 1, first arbitration SHALL occur on the following rising edge.

Verification
REQ-029 Reset release, req0=1 we0=0 addr0=0x10, mem holds 0xDEADBEEF -> gnt0 in cycle 1, rvalid0=1 rdata0=0xDEADBEEF in cycle 2, gnt1 never.
REQ-030 req0 and req1 both high continuously, MAX_BURST=4 -> gnt0 4 cycles, gnt1 4 cycles, alternating with no bubble, never simultaneous.
REQ-031 req1 only, we1=1 addr1=0x20 wdata1=0x12345678 for 6 cycles -> gnt1 6 consecutive cycles, mem_we=1, mem_wdata=0x12345678, rvalid1 stays 0.
REQ-032 Both requests raised simultaneously from IDLE after reset -> requester 0 granted first; repeat after requester 0 drops -> requester 1 granted first.
REQ-033 OWN0 ownership with req0 dropping while req1 high -> one cycle with gnt0=gnt1=0, then gnt1.
REQ-034 rst pulsed low during a 3-beat read burst on requester 0 -> gnt0, rvalid0, mem_we all 0 immediately, rdata0=0, FSM in IDLE.
